// File: rtl/pb_conditioner.sv
// Push-button conditioner: synchronise, debounce and edge-detect each button, then issue one-hot strobes.
// Optional auto-repeat on held buttons when PB_AUTOREPEAT_EN is defined.
module pb_conditioner #(
    parameter int NBTN       = 5,
    parameter int DB_CYCLES  = 500000,
    parameter int CNT_W      = 20,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_CYCLES = 10000000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NBTN-1:0] BTN_IN,
    output logic [NBTN-1:0] PB,
    output logic [NBTN-1:0] BTN_LEVEL,
    output logic            BUSY
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_CYCLES < 1) begin : g_bad_cfg
        $error("pb_conditioner: DB_CYCLES must be >= 2 and repeat intervals >= 1");
    end

    logic [NBTN-1:0] stable_lvl;
    logic [NBTN-1:0] set_vec;
    logic [NBTN-1:0] issue;
    logic [NBTN-1:0] pending_q, pending_d;
    logic [NBTN-1:0] pb_q;
    logic            busy_q;

    genvar gi;
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
        logic             s1_q, s2_q, stable_q;
        logic [CNT_W-1:0] cnt_q;
        logic             mismatch;
        logic             accept;

        assign mismatch = (s2_q != stable_q);
        assign accept   = mismatch && (cnt_q == DB_LAST);

        // Counter only advances while the synchronised level disagrees with the accepted one
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q <= BTN_IN[gi];
                s2_q <= s1_q;
                if (!mismatch) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    cnt_q    <= '0;
                    stable_q <= s2_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign stable_lvl[gi] = stable_q;

`ifdef PB_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
        localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CYCLES - 1);

        logic [CNT_W-1:0] hold_q;
        logic             rep_q;
        logic             fire;

        // First repeat waits the long delay, later ones use the shorter period
        assign fire = stable_q && (rep_q ? (hold_q == RPT_LAST) : (hold_q == DLY_LAST));

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
            end else if (!stable_q) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
            end else if (fire) begin
                hold_q <= '0;
                rep_q  <= 1'b1;
            end else begin
                hold_q <= hold_q + CNT_W'(1);
            end
        end

        assign set_vec[gi] = (accept && s2_q) || fire;
`else
        assign set_vec[gi] = accept && s2_q;
`endif
    end

    // Lowest-index pending request wins; new requests never clear on the edge they arrive
    assign issue     = pending_q & (~pending_q + NBTN'(1));
    assign pending_d = (pending_q & ~issue) | set_vec;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= '0;
            pb_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            pb_q      <= issue;
            busy_q    <= |pending_d;
        end
    end

    assign PB        = pb_q;
    assign BTN_LEVEL = stable_lvl;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with short debounce/repeat timings.
module tb_pb_conditioner;

    localparam int NBTN       = 5;
    localparam int DB_CYCLES  = 4;
    localparam int CNT_W      = 8;
    localparam int RPT_DELAY  = 20;
    localparam int RPT_CYCLES = 8;

    logic            CLK;
    logic            RESET;
    logic [NBTN-1:0] BTN_IN;
    logic [NBTN-1:0] PB;
    logic [NBTN-1:0] BTN_LEVEL;
    logic            BUSY;

    int checks = 0;
    int errors = 0;

    pb_conditioner #(
        .NBTN      (NBTN),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .RPT_DELAY (RPT_DELAY),
        .RPT_CYCLES(RPT_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_IN   (BTN_IN),
        .PB       (PB),
        .BTN_LEVEL(BTN_LEVEL),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        BTN_IN = '0;
        RESET  = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        BTN_IN = '1;
        RESET  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PB !== 5'b0) begin
                errors++;
                $display("FAIL reset_pb i=%0d got %b exp %b", i, PB, 5'b0);
            end
            checks++;
            if (BTN_LEVEL !== 5'b0) begin
                errors++;
                $display("FAIL reset_level i=%0d got %b exp %b", i, BTN_LEVEL, 5'b0);
            end
            checks++;
            if (BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy i=%0d got %b exp %b", i, BUSY, 1'b0);
            end
        end
        BTN_IN = '0;
        RESET  = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    // Shared press-timing check: i counts edges after the first sampling edge
    task automatic check_press(input string name, input logic [NBTN-1:0] btn);
        logic [NBTN-1:0] exp_lvl, exp_pb;
        logic            exp_busy;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_lvl  = (i >= DB_CYCLES + 1) ? btn : '0;
            exp_pb   = (i == DB_CYCLES + 2) ? btn : '0;
            exp_busy = (i == DB_CYCLES + 1);
            checks++;
            if (BTN_LEVEL !== exp_lvl) begin
                errors++;
                $display("FAIL %s_level i=%0d got %b exp %b", name, i, BTN_LEVEL, exp_lvl);
            end
            checks++;
            if (PB !== exp_pb) begin
                errors++;
                $display("FAIL %s_pb i=%0d got %b exp %b", name, i, PB, exp_pb);
            end
            checks++;
            if (BUSY !== exp_busy) begin
                errors++;
                $display("FAIL %s_busy i=%0d got %b exp %b", name, i, BUSY, exp_busy);
            end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        BTN_IN = 5'b00100;
        check_press("single", 5'b00100);
        BTN_IN = '0;
        $display("test_single_press done");
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            BTN_IN = ((i % 4) != 3) ? 5'b00001 : 5'b00000;
            tick();
            checks++;
            if (PB !== 5'b0) begin
                errors++;
                $display("FAIL glitch_pb i=%0d got %b exp %b", i, PB, 5'b0);
            end
            checks++;
            if (BTN_LEVEL !== 5'b0) begin
                errors++;
                $display("FAIL glitch_level i=%0d got %b exp %b", i, BTN_LEVEL, 5'b0);
            end
        end
        BTN_IN = '0;
        $display("test_glitch done");
    endtask

    task automatic test_back_to_back();
        logic [NBTN-1:0] exp_lvl, exp_pb;
        logic            exp_busy;
        do_reset();
        BTN_IN = 5'b01011;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_lvl  = (i >= 5) ? 5'b01011 : 5'b00000;
            exp_pb   = (i == 6) ? 5'b00001 : (i == 7) ? 5'b00010 : (i == 8) ? 5'b01000 : 5'b00000;
            exp_busy = (i >= 5) && (i <= 7);
            checks++;
            if (BTN_LEVEL !== exp_lvl) begin
                errors++;
                $display("FAIL b2b_level i=%0d got %b exp %b", i, BTN_LEVEL, exp_lvl);
            end
            checks++;
            if (PB !== exp_pb) begin
                errors++;
                $display("FAIL b2b_pb i=%0d got %b exp %b", i, PB, exp_pb);
            end
            checks++;
            if (BUSY !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy i=%0d got %b exp %b", i, BUSY, exp_busy);
            end
        end
        BTN_IN = '0;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        BTN_IN = 5'b00010;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (BTN_LEVEL !== 5'b00010) begin
            errors++;
            $display("FAIL mid_level_pre got %b exp %b", BTN_LEVEL, 5'b00010);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_pre got %b exp %b", BUSY, 1'b1);
        end
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({PB, BTN_LEVEL, BUSY} !== 11'b0) begin
                errors++;
                $display("FAIL mid_in_reset i=%0d got %b exp %b", i, {PB, BTN_LEVEL, BUSY}, 11'b0);
            end
            if (i < 2) tick();
        end
        RESET = 1'b0;
        check_press("mid_after", 5'b00010);
        BTN_IN = '0;
        $display("test_reset_mid done");
    endtask

    task automatic test_release_bounce();
        int              strobes;
        logic [NBTN-1:0] exp_lvl;
        strobes = 0;
        do_reset();
        BTN_IN = 5'b01000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (PB != 5'b0) strobes++;
        end
        BTN_IN = 5'b00000;
        tick();
        if (PB != 5'b0) strobes++;
        BTN_IN = 5'b01000;
        tick();
        if (PB != 5'b0) strobes++;
        tick();
        if (PB != 5'b0) strobes++;
        BTN_IN = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (PB != 5'b0) strobes++;
            exp_lvl = (i < 5) ? 5'b01000 : 5'b00000;
            checks++;
            if (BTN_LEVEL !== exp_lvl) begin
                errors++;
                $display("FAIL bounce_level i=%0d got %b exp %b", i, BTN_LEVEL, exp_lvl);
            end
        end
        checks++;
        if (strobes !== 1) begin
            errors++;
            $display("FAIL bounce_strobes got %0d exp %0d", strobes, 1);
        end
        $display("test_release_bounce done");
    endtask

    task automatic test_hold();
        logic [NBTN-1:0] exp_pb;
        logic            rpt;
        do_reset();
        BTN_IN = 5'b10000;
        for (int i = 0; i < 60; i++) begin
            tick();
`ifdef PB_AUTOREPEAT_EN
            rpt = (i >= 26) && (((i - 26) % 8) == 0);
`else
            rpt = 1'b0;
`endif
            exp_pb = ((i == 6) || rpt) ? 5'b10000 : 5'b00000;
            checks++;
            if (PB !== exp_pb) begin
                errors++;
                $display("FAIL hold_pb i=%0d got %b exp %b", i, PB, exp_pb);
            end
        end
        BTN_IN = '0;
        for (int i = 0; i < 8; i++) tick();
        $display("test_hold done");
    endtask

    initial begin
        RESET  = 1'b1;
        BTN_IN = '0;
        test_reset();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_release_bounce();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
